hyperbus_target: RTL

HYPERBUS_TARGET -- requirements
Module: hyperbus_target

---
 rtl/hyperbus_pkg.sv | 25 ++
 rtl/hyperbus_target_mem.sv | 23 ++
 rtl/hyperbus_target.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the HyperBus target.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WRITE,
        ST_READ,
        ST_REGWR
    } state_t;

    // Command/address word field positions
    localparam int CA_RW_BIT  = 47;  // 1 = read
    localparam int CA_AS_BIT  = 46;  // 1 = register space
    localparam int CA_BT_BIT  = 45;  // 1 = linear burst, 0 = wrapped
    localparam int CA_ROW_HI  = 35;
    localparam int CA_ROW_LO  = 16;
    localparam int CA_COL_HI  = 2;
    localparam int CA_BYTES   = 6;

    localparam logic [15:0] CR0_RESET   = 16'h8F1F;
    localparam logic [15:0] ID0_DEFAULT = 16'h0C81;

endpackage

// File: rtl/hyperbus_target_mem.sv
// Byte-enabled 2x8-bit synchronous RAM, one-cycle read latency, no reset.
module hyperbus_target_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [1:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [7:0] mem_hi [2**AW];
    logic [7:0] mem_lo [2**AW];

    // Byte-lane writes and registered read
    always_ff @(posedge clk) begin
        if (we[1]) mem_hi[waddr] <= wdata[15:8];
        if (we[0]) mem_lo[waddr] <= wdata[7:0];
        rdata <= {mem_hi[raddr], mem_lo[raddr]};
    end

endmodule

// File: rtl/hyperbus_target.sv
// HyperBus target: CA capture, fixed 2x latency, memory and register bursts.
module hyperbus_target
    import hyperbus_pkg::*;
#(
    parameter int          MEM_AW  = 10,
    parameter int          LATENCY = 6,
    parameter logic [15:0] ID0     = ID0_DEFAULT
) (
    input  logic        clock200,
    input  logic        reset_n,
    input  logic        cs_n,
    input  logic [7:0]  dq_in,
    input  logic        rwds_in,
    output logic [7:0]  dq_out,
    output logic        dq_oe,
    output logic        rwds_out,
    output logic        rwds_oe,
    output logic        busy,
    output logic        ca_valid,
    output logic [47:0] ca_word
);

    localparam int LAT_CYC = 4 * LATENCY;
    localparam int LCW     = (LAT_CYC > 2) ? $clog2(LAT_CYC) : 1;

    state_t            state, state_next;
    logic [39:0]       ca_sr;
    logic [47:0]       ca_full;
    logic [2:0]        byte_cnt;
    logic [LCW-1:0]    lat_cnt;
    logic [MEM_AW-1:0] addr, addr_next, rd_addr;
    logic              is_read, is_reg, is_linear, upper;
    logic [15:0]       cr0, reg_rd, mem_rdata, rd_word;
    logic [1:0]        we;

    assign ca_full = {ca_sr, dq_in};
    assign busy    = (state != ST_IDLE);
    assign rd_word = is_reg ? reg_rd : mem_rdata;

    // Burst address step: linear wraps at the top of memory, wrapped stays in a 16-word group
    always_comb begin
        addr_next = addr + MEM_AW'(1);
        if (!is_linear) addr_next = {addr[MEM_AW-1:4], addr[3:0] + 4'd1};
    end

    // Read address runs one word ahead on lower bytes so the next word is ready on time
    always_comb begin
        rd_addr = addr;
        if (state == ST_READ && !upper) rd_addr = addr_next;
    end

    // Write enables: one lane per bus byte, suppressed by the host mask
    always_comb begin
        we = '0;
        if (state == ST_WRITE && !cs_n && !rwds_in) we = upper ? 2'b10 : 2'b01;
    end

    // State register
    always_ff @(posedge clock200 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state and bus output decode
    always_comb begin
        state_next = state;
        dq_out     = '0;
        dq_oe      = 1'b0;
        rwds_out   = 1'b0;
        rwds_oe    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_n) state_next = ST_CA;
            end
            ST_CA: begin
                rwds_oe  = 1'b1;
                rwds_out = 1'b1;
                if (byte_cnt == 3'(CA_BYTES - 1)) begin
                    if (!ca_full[CA_RW_BIT] && ca_full[CA_AS_BIT]) state_next = ST_REGWR;
                    else                                            state_next = ST_LAT;
                end
            end
            ST_LAT: begin
                if (lat_cnt == LCW'(LAT_CYC - 1)) state_next = is_read ? ST_READ : ST_WRITE;
            end
            ST_READ: begin
                dq_oe    = 1'b1;
                rwds_oe  = 1'b1;
                rwds_out = upper;
                dq_out   = upper ? rd_word[15:8] : rd_word[7:0];
            end
            default: ;
        endcase
        if (cs_n) state_next = ST_IDLE;
    end

    // Datapath: CA shift, counters, burst address, CR0 and register read prefetch
    always_ff @(posedge clock200 or negedge reset_n) begin
        if (!reset_n) begin
            ca_sr     <= '0;
            ca_word   <= '0;
            ca_valid  <= 1'b0;
            byte_cnt  <= '0;
            lat_cnt   <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            is_reg    <= 1'b0;
            is_linear <= 1'b0;
            upper     <= 1'b0;
            cr0       <= CR0_RESET;
            reg_rd    <= '0;
        end else begin
            ca_valid <= 1'b0;
            reg_rd   <= rd_addr[0] ? cr0 : ID0;
            case (state)
                ST_IDLE: begin
                    if (!cs_n) begin
                        ca_sr    <= {32'h0, dq_in};
                        byte_cnt <= 3'd1;
                    end
                end
                ST_CA: begin
                    if (!cs_n) begin
                        ca_sr    <= {ca_sr[31:0], dq_in};
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'(CA_BYTES - 1)) begin
                            ca_word   <= ca_full;
                            ca_valid  <= 1'b1;
                            is_read   <= ca_full[CA_RW_BIT];
                            is_reg    <= ca_full[CA_AS_BIT];
                            is_linear <= ca_full[CA_BT_BIT];
                            addr      <= MEM_AW'({ca_full[CA_ROW_HI:CA_ROW_LO], ca_full[CA_COL_HI:0]});
                            lat_cnt   <= '0;
                            byte_cnt  <= '0;
                            upper     <= 1'b1;
                        end
                    end
                end
                ST_LAT: begin
                    lat_cnt <= lat_cnt + LCW'(1);
                end
                ST_WRITE, ST_READ: begin
                    if (!cs_n) begin
                        upper <= ~upper;
                        if (!upper) addr <= addr_next;
                    end
                end
                ST_REGWR: begin
                    if (!cs_n && byte_cnt < 3'd2) begin
                        byte_cnt <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'd0) cr0[15:8] <= dq_in;
                        else                  cr0[7:0]  <= dq_in;
                    end
                end
                default: ;
            endcase
        end
    end

    hyperbus_target_mem #(.AW(MEM_AW)) u_mem (
        .clk   (clock200),
        .we    (we),
        .waddr (addr),
        .wdata ({dq_in, dq_in}),
        .raddr (rd_addr),
        .rdata (mem_rdata)
    );

endmodule
